int_to_float: RTL

- Pipelined converter from a signed two's-complement fixed-point integer to the codebase's p_float format (sign, exp, frac).
- Feeds the float datapath (add/mul cores) from integer sources such as pixel counters, sample indices and LFSR outputs.
- Fully pipelined: accepts one input per clock, fixed latency, with a valid bit carried alongside the data.

---
 rtl/int_to_float_if.sv | 27 ++
 rtl/int_to_float.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/int_to_float_if.sv
// Bundle for int_to_float: sample in, p_float result out.
// The p_float field widths come from `P_FRAC and `P_EXP, which default to single precision here.
`ifndef P_FRAC
`define P_FRAC 23
`endif
`ifndef P_EXP
`define P_EXP 7
`endif

interface int_to_float_if #(
  parameter int IN_W = 32
);
  typedef struct packed {
    logic                   sign;
    logic signed [`P_EXP:0] exp;
    logic [`P_FRAC:0]       frac;
  } p_float_t;

  logic                   in_valid;
  logic signed [IN_W-1:0] in_data;
  logic                   out_valid;
  p_float_t               out;
  logic                   out_zero;

  modport master (output in_valid, in_data, input out_valid, out, out_zero);
  modport slave  (input in_valid, in_data, output out_valid, out, out_zero);
endinterface

// File: rtl/int_to_float.sv
// int_to_float: 7-stage signed fixed-point to p_float converter, one sample per clock.
// Macro INT_TO_FLOAT_RNE_EN selects round-to-nearest-even; when undefined the mantissa truncates.
`ifndef P_FRAC
`define P_FRAC 23
`endif
`ifndef P_EXP
`define P_EXP 7
`endif

module int_to_float #(
  parameter int IN_W  = 32,
  parameter int POINT = 0
) (
  input logic           clk,
  input logic           rst,
  int_to_float_if.slave bus
);
  localparam int F   = `P_FRAC + 1;
  localparam int EW  = `P_EXP + 1;
  localparam int LZW = $clog2(IN_W);
  // Zero padding below the magnitude keeps guard/round/sticky defined for any IN_W.
  localparam int PAD = F + 3;
  localparam int NW  = IN_W + PAD;
`ifdef INT_TO_FLOAT_RNE_EN
  localparam int NORM_W = NW;
`else
  localparam int NORM_W = F;
`endif

  if (IN_W < 2 || IN_W + POINT >= (1 << `P_EXP)) begin : g_param_check
    $error("int_to_float: IN_W/POINT do not fit the p_float exponent range");
  end

  function automatic logic [LZW-1:0] lzc_f(input logic [IN_W-1:0] v);
    logic [LZW-1:0] n;
    n = '0;
    for (int i = 0; i < IN_W; i++)
      if (v[i]) n = LZW'(IN_W - 1 - i);
    return n;
  endfunction

`ifdef INT_TO_FLOAT_RNE_EN
  function automatic logic rne_up(input logic lsb, input logic guard,
                                  input logic round, input logic sticky);
    return guard & (round | sticky | lsb);
  endfunction
`endif

  logic                   vld_p1, vld_p2, vld_p3, vld_p4, vld_p5, vld_p6;
  logic signed [IN_W-1:0] data_p1;
  logic                   sign_p1, sign_p2, sign_p3, sign_p4, sign_p5, sign_p6;
  logic                   zero_p1, zero_p2, zero_p3, zero_p4, zero_p5, zero_p6;
  logic [IN_W-1:0]        mag_p2, mag_p3;
  logic [LZW-1:0]         lzc_p3;
  logic [NORM_W-1:0]      norm_p4;
  logic signed [EW-1:0]   exp_p4, exp_p5, exp_p6;
  logic [F-1:0]           frac_p5, frac_p6;
`ifdef INT_TO_FLOAT_RNE_EN
  logic                   rup_p5;
  logic [F:0]             sum_p5;

  assign sum_p5 = {1'b0, frac_p5} + {{F{1'b0}}, rup_p5};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      vld_p4 <= 1'b0;
      vld_p5 <= 1'b0;
      vld_p6 <= 1'b0;
    end else begin
      vld_p1 <= bus.in_valid;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      vld_p4 <= vld_p3;
      vld_p5 <= vld_p4;
      vld_p6 <= vld_p5;
    end
  end

  always_ff @(posedge clk) begin
    // p1: capture operand, sign and zero flag
    data_p1 <= bus.in_data;
    sign_p1 <= bus.in_data[IN_W-1];
    zero_p1 <= (bus.in_data == '0);
    // p2: magnitude; -2^(IN_W-1) maps to itself as unsigned
    mag_p2  <= sign_p1 ? unsigned'(-data_p1) : unsigned'(data_p1);
    sign_p2 <= sign_p1;
    zero_p2 <= zero_p1;
    // p3: leading-zero count
    lzc_p3  <= lzc_f(mag_p2);
    mag_p3  <= mag_p2;
    sign_p3 <= sign_p2;
    zero_p3 <= zero_p2;
    // p4: normalize and form the unbiased exponent
    norm_p4 <= NORM_W'(({mag_p3, {PAD{1'b0}}} << lzc_p3) >> (NW - NORM_W));
    exp_p4  <= EW'(IN_W - 1 - POINT - int'(lzc_p3));
    sign_p4 <= sign_p3;
    zero_p4 <= zero_p3;
    // p5: mantissa select and rounding decision
`ifdef INT_TO_FLOAT_RNE_EN
    frac_p5 <= norm_p4[NW-1 -: F];
    rup_p5  <= rne_up(norm_p4[NW-F], norm_p4[NW-1-F], norm_p4[NW-2-F], |norm_p4[NW-3-F:0]);
`else
    frac_p5 <= norm_p4;
`endif
    exp_p5  <= exp_p4;
    sign_p5 <= sign_p4;
    zero_p5 <= zero_p4;
    // p6: apply rounding; a carry-out renormalizes to 1.000 and bumps the exponent
`ifdef INT_TO_FLOAT_RNE_EN
    if (sum_p5[F]) begin
      frac_p6 <= sum_p5[F:1];
      exp_p6  <= exp_p5 + EW'(1);
    end else begin
      frac_p6 <= sum_p5[F-1:0];
      exp_p6  <= exp_p5;
    end
`else
    frac_p6 <= frac_p5;
    exp_p6  <= exp_p5;
`endif
    sign_p6 <= sign_p5;
    zero_p6 <= zero_p5;
  end

  // p7: output register, cleared on reset so the result port reads all-zero
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_zero  <= 1'b0;
      bus.out       <= '0;
    end else begin
      bus.out_valid <= vld_p6;
      bus.out_zero  <= zero_p6;
      if (zero_p6) begin
        bus.out.sign <= 1'b0;
        bus.out.exp  <= {1'b1, {(EW-1){1'b0}}};
        bus.out.frac <= '0;
      end else begin
        bus.out.sign <= sign_p6;
        bus.out.exp  <= exp_p6;
        bus.out.frac <= frac_p6;
      end
    end
  end
endmodule
